// File: rtl/joker_ep_in_buf_pkg.sv
// Shared constants and FSM state encoding for the EP1 IN reply buffer.
package joker_ep_in_buf_pkg;

  localparam int JOKER_ADDR_W  = 11;
  localparam int JOKER_MAX_PKT = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_TOK = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_RELEASE  = 3'd5
  } joker_ep_in_state_e;

endpackage

// File: rtl/joker_ep_in_buf_if.sv
// Reply-write bus from the command engine plus the IN stream to the USB device core.
interface joker_ep_in_buf_if
  import joker_ep_in_buf_pkg::*;
#(
  parameter int ADDR_W = JOKER_ADDR_W
);
  logic [ADDR_W-1:0] usb_in_addr;
  logic [7:0]        usb_in_data;
  logic              usb_in_wren;
  logic              usb_in_commit;
  logic [ADDR_W-1:0] usb_in_commit_len;
  logic              usb_in_commit_ack;
  logic              usb_in_ready;
  logic              tx_tok;
  logic              tx_nak;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_last;
  logic              tx_zlp;
  logic              tx_ready;
  logic              tx_done;
  logic              tx_abort;

  modport master (
    output usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit, usb_in_commit_len,
    output tx_tok, tx_ready, tx_done, tx_abort,
    input  usb_in_commit_ack, usb_in_ready, tx_nak, tx_valid, tx_data, tx_last, tx_zlp
  );

  modport slave (
    input  usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit, usb_in_commit_len,
    input  tx_tok, tx_ready, tx_done, tx_abort,
    output usb_in_commit_ack, usb_in_ready, tx_nak, tx_valid, tx_data, tx_last, tx_zlp
  );
endinterface

// File: rtl/joker_ep_in_ram.sv
// Simple dual-port byte RAM: client write port, registered read port.
module joker_ep_in_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/joker_ep_in_buf.sv
// EP1 IN reply buffer: splits a committed reply into MAX_PKT IN transactions.
// Trailing ZLP after a reply ending on a packet boundary is enabled by JOKER_EP_IN_ZLP_EN.
module joker_ep_in_buf
  import joker_ep_in_buf_pkg::*;
#(
  parameter int ADDR_W  = JOKER_ADDR_W,
  parameter int MAX_PKT = JOKER_MAX_PKT
) (
  input  logic               clk,
  input  logic               reset,
  joker_ep_in_buf_if.slave   bus
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] MAX_PKT_C = CW'(MAX_PKT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(2**ADDR_W);

  joker_ep_in_state_e state_q, state_d;
  logic [CW-1:0] base_q, base_d, remain_q, remain_d, chunk_q, chunk_d, idx_q, idx_d;
  logic          zlp_q, zlp_d, owed_q, owed_d, vld_q, vld_d, nak_q, nak_d;
  logic          accept, lastBeat, startSend;
  logic [CW-1:0] rdOff, lenRaw, lenClamped;
  logic [7:0]    ramData;

  joker_ep_in_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk      (clk),
    .wr_en_i  (bus.usb_in_wren),
    .wr_addr_i(bus.usb_in_addr),
    .wr_data_i(bus.usb_in_data),
    .rd_addr_i(ADDR_W'(base_q + rdOff)),
    .rd_data_o(ramData)
  );

  assign accept     = vld_q & bus.tx_ready;
  assign lastBeat   = zlp_q | (idx_q == chunk_q - CW'(1));
  assign startSend  = bus.tx_tok & ((remain_q != '0) | owed_q);
  assign lenRaw     = CW'(bus.usb_in_commit_len);
  assign lenClamped = (lenRaw > DEPTH_C) ? DEPTH_C : lenRaw;

  // The read address normally holds on the current byte; it steps ahead on accept so
  // the next byte lands in the registered read output in time for a back-to-back beat.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    remain_d = remain_q;
    chunk_d  = chunk_q;
    idx_d    = idx_q;
    zlp_d    = zlp_q;
    owed_d   = owed_q;
    vld_d    = vld_q;
    nak_d    = 1'b0;
    rdOff    = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        nak_d = bus.tx_tok;
        if (bus.usb_in_commit) begin
          state_d  = ST_WAIT_TOK;
          remain_d = lenClamped;
          base_d   = '0;
          owed_d   = (lenClamped == '0);
        end
      end
      ST_WAIT_TOK: begin
        if (startSend) begin
          state_d = ST_SEND;
          chunk_d = (remain_q > MAX_PKT_C) ? MAX_PKT_C : remain_q;
          zlp_d   = (remain_q == '0);
          idx_d   = '0;
          vld_d   = 1'b0;
        end else begin
          nak_d = bus.tx_tok;
        end
      end
      ST_SEND: begin
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (accept) begin
          if (lastBeat) begin
            vld_d   = 1'b0;
            state_d = ST_WAIT_ACK;
          end else begin
            idx_d = idx_q + CW'(1);
            rdOff = idx_q + CW'(1);
          end
        end
      end
      ST_WAIT_ACK: begin
        if (bus.tx_abort) begin
          state_d = ST_WAIT_TOK;
        end else if (bus.tx_done) begin
          if (zlp_q) begin
            owed_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            base_d   = base_q + chunk_q;
            remain_d = remain_q - chunk_q;
            state_d  = ST_WAIT_TOK;
            if (remain_q == chunk_q) begin
`ifdef JOKER_EP_IN_ZLP_EN
              // A reply ending on a full packet needs a ZLP so the host sees it end.
              owed_d  = (chunk_q == MAX_PKT_C);
              state_d = (chunk_q == MAX_PKT_C) ? ST_WAIT_TOK : ST_DONE;
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
      end
      ST_DONE: begin
        nak_d   = bus.tx_tok;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        nak_d = bus.tx_tok;
        if (!bus.usb_in_commit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      remain_q <= '0;
      chunk_q  <= '0;
      idx_q    <= '0;
      zlp_q    <= 1'b0;
      owed_q   <= 1'b0;
      vld_q    <= 1'b0;
      nak_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      remain_q <= remain_d;
      chunk_q  <= chunk_d;
      idx_q    <= idx_d;
      zlp_q    <= zlp_d;
      owed_q   <= owed_d;
      vld_q    <= vld_d;
      nak_q    <= nak_d;
    end
  end

  // Stream outputs are gated by reset so a mid-transfer reset drops tx_valid immediately.
  assign bus.tx_valid          = vld_q & reset;
  assign bus.tx_last           = bus.tx_valid & lastBeat;
  assign bus.tx_zlp            = bus.tx_valid & zlp_q;
  assign bus.tx_data           = (bus.tx_valid && !zlp_q) ? ramData : 8'h00;
  assign bus.tx_nak            = nak_q;
  assign bus.usb_in_ready      = (state_q == ST_IDLE);
  assign bus.usb_in_commit_ack = (state_q == ST_WAIT_TOK) || (state_q == ST_SEND) ||
                                 (state_q == ST_WAIT_ACK);

endmodule

// File: tb/tb_joker_ep_in_buf.sv
// Directed table-driven bench for the EP1 IN reply buffer (ADDR_W=11, MAX_PKT=64).
module tb_joker_ep_in_buf;

`ifdef JOKER_EP_IN_ZLP_EN
  localparam int ZE = 1;
`else
  localparam int ZE = 0;
`endif

  typedef struct {
    int len;
    int seed;
    int toggle;
    int abortPkt;
    int abortBoth;
    int nData;
    int lastSize;
    int trailZlp;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   refMem [2048];
  vec_t vecs [8];

  joker_ep_in_buf_if #(.ADDR_W(11)) bus ();

  joker_ep_in_buf #(.ADDR_W(11), .MAX_PKT(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tokenPulse();
    bus.tx_tok = 1'b1;
    tick();
    bus.tx_tok = 1'b0;
  endtask

  task automatic writeByte(input int addr, input int value);
    bus.usb_in_addr = 11'(addr);
    bus.usb_in_data = 8'(value);
    bus.usb_in_wren = 1'b1;
    refMem[addr]    = value & 255;
    tick();
    bus.usb_in_wren = 1'b0;
  endtask

  // Receives one IN transaction and compares every beat against the reference bytes.
  task automatic recvPacket(input int off, input int size, input int zlp, input int toggle,
                            input string tag);
    int waitc = 0;
    int beats = 0;
    int cyc   = 0;
    int want  = (zlp != 0) ? 1 : size;
    bit fin   = 1'b0;
    bus.tx_ready = 1'b1;
    while (!bus.tx_valid && waitc < 8) begin
      tick();
      waitc++;
    end
    checkOutput({tag, " valid latency"}, waitc, 1);
    while (!fin && cyc < 4 * size + 16) begin
      bus.tx_ready = (toggle == 0) || ((cyc % 2) == 0);
      if (bus.tx_valid && bus.tx_ready) begin
        if (zlp != 0) begin
          checkOutput({tag, " zlp flag"}, int'(bus.tx_zlp), 1);
          checkOutput({tag, " zlp last"}, int'(bus.tx_last), 1);
        end else begin
          checkOutput($sformatf("%s data[%0d]", tag, off + beats), int'(bus.tx_data),
                      refMem[off + beats]);
          checkOutput($sformatf("%s last[%0d]", tag, beats), int'(bus.tx_last),
                      int'(beats == size - 1));
          checkOutput($sformatf("%s zlp[%0d]", tag, beats), int'(bus.tx_zlp), 0);
        end
        beats++;
        if (bus.tx_last || beats == want) fin = 1'b1;
      end
      tick();
      cyc++;
    end
    bus.tx_ready = 1'b1;
    checkOutput({tag, " beat count"}, beats, want);
    checkOutput({tag, " valid after last"}, int'(bus.tx_valid), 0);
  endtask

  // Runs one full reply: write, commit, all transactions, ack fall and release.
  task automatic applyStimulus(input vec_t v, input string tag);
    int waitc = 0;
    int nPk   = v.nData + v.trailZlp;
    while (!bus.usb_in_ready && waitc < 10) begin
      tick();
      waitc++;
    end
    checkOutput({tag, " ready before"}, int'(bus.usb_in_ready), 1);
    if (v.seed >= 0) begin
      for (int i = 0; i < v.len; i++) writeByte(i, (v.seed + i * 37) & 255);
    end
    bus.usb_in_commit     = 1'b1;
    bus.usb_in_commit_len = 11'(v.len);
    tick();
    checkOutput({tag, " ack on accept"}, int'(bus.usb_in_commit_ack), 1);
    checkOutput({tag, " ready busy"}, int'(bus.usb_in_ready), 0);
    for (int p = 0; p < nPk; p++) begin
      int    isZlp = (p >= v.nData) ? 1 : 0;
      int    size  = (isZlp != 0) ? 0 : ((p == v.nData - 1) ? v.lastSize : 64);
      string ptag  = $sformatf("%s pkt%0d", tag, p);
      tokenPulse();
      recvPacket(p * 64, size, isZlp, v.toggle, ptag);
      tokenPulse();
      checkOutput({ptag, " no nak in wait_ack"}, int'(bus.tx_nak), 0);
      if (p == v.abortPkt) begin
        bus.tx_abort = 1'b1;
        bus.tx_done  = (v.abortBoth != 0);
        tick();
        bus.tx_abort = 1'b0;
        bus.tx_done  = 1'b0;
        checkOutput({ptag, " ack after abort"}, int'(bus.usb_in_commit_ack), 1);
        tokenPulse();
        recvPacket(p * 64, size, isZlp, v.toggle, {ptag, " replay"});
      end
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      checkOutput({ptag, " ack after done"}, int'(bus.usb_in_commit_ack),
                  (p == nPk - 1) ? 0 : 1);
    end
    tick();
    tick();
    checkOutput({tag, " no re-accept"}, int'(bus.usb_in_ready), 0);
    checkOutput({tag, " ack stays low"}, int'(bus.usb_in_commit_ack), 0);
    bus.usb_in_commit = 1'b0;
    waitc = 0;
    while (!bus.usb_in_ready && waitc < 6) begin
      tick();
      waitc++;
    end
    checkOutput({tag, " ready after release"}, int'(bus.usb_in_ready), 1);
  endtask

  initial begin
    vec_t hand;
    checks                = 0;
    failures              = 0;
    reset                 = 1'b0;
    bus.usb_in_addr       = '0;
    bus.usb_in_data       = '0;
    bus.usb_in_wren       = 1'b0;
    bus.usb_in_commit     = 1'b0;
    bus.usb_in_commit_len = '0;
    bus.tx_tok            = 1'b0;
    bus.tx_ready          = 1'b1;
    bus.tx_done           = 1'b0;
    bus.tx_abort          = 1'b0;

    //           len  seed tog abort both nData last trailZlp
    vecs[0] = '{150,   3, 0, -1, 0,  3, 22, 0};
    vecs[1] = '{150,   5, 0,  1, 0,  3, 22, 0};
    vecs[2] = '{ 65,   9, 1, -1, 0,  2,  1, 0};
    vecs[3] = '{ 40,  11, 1,  0, 1,  1, 40, 0};
    vecs[4] = '{128,  13, 0, -1, 0,  2, 64, ZE};
    vecs[5] = '{ 64,  17, 0, -1, 0,  1, 64, ZE};
    vecs[6] = '{  0,  19, 0, -1, 0,  0,  0, 1};
    vecs[7] = '{2047, 21, 0, -1, 0, 32, 63, 0};

    tick();
    tick();
    checkOutput("reset ready", int'(bus.usb_in_ready), 1);
    checkOutput("reset ack", int'(bus.usb_in_commit_ack), 0);
    checkOutput("reset valid", int'(bus.tx_valid), 0);
    checkOutput("reset nak", int'(bus.tx_nak), 0);
    checkOutput("reset last", int'(bus.tx_last), 0);
    checkOutput("reset zlp", int'(bus.tx_zlp), 0);
    checkOutput("reset data", int'(bus.tx_data), 0);
    reset = 1'b1;
    tick();

    tokenPulse();
    checkOutput("idle token nak", int'(bus.tx_nak), 1);
    checkOutput("idle token valid", int'(bus.tx_valid), 0);
    tick();
    checkOutput("idle nak one cycle", int'(bus.tx_nak), 0);

    writeByte(0, 8'h0A);
    writeByte(1, 8'h5C);
    hand = '{2, -1, 0, -1, 0, 1, 2, 0};
    applyStimulus(hand, "two byte");

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 100; i++) writeByte(i, (i * 11 + 3) & 255);
    bus.usb_in_commit     = 1'b1;
    bus.usb_in_commit_len = 11'd100;
    tick();
    tokenPulse();
    bus.tx_ready = 1'b0;
    tick();
    tick();
    checkOutput("midsend valid held", int'(bus.tx_valid), 1);
    checkOutput("midsend data held", int'(bus.tx_data), 3);
    reset             = 1'b0;
    bus.usb_in_commit = 1'b0;
    tick();
    checkOutput("midsend reset valid", int'(bus.tx_valid), 0);
    checkOutput("midsend reset ready", int'(bus.usb_in_ready), 1);
    checkOutput("midsend reset ack", int'(bus.usb_in_commit_ack), 0);
    reset        = 1'b1;
    bus.tx_ready = 1'b1;
    tick();
    tokenPulse();
    checkOutput("post reset nak", int'(bus.tx_nak), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/joker_ep_in_buf.md
Name: joker_ep_in_buf

Overview:
- EP1 IN reply buffer: the reader/drainer for the command engine's reply-write interface.
- Command engine side: byte-addressed writes into a 2 KiB buffer, then a level `usb_in_commit` with `usb_in_commit_len`.
- Block splits the committed reply into MAX_PKT-sized USB IN transactions and streams them to the USB device core on IN tokens.
- Completion is signalled with the commit_ack rise/fall handshake; NAKs IN tokens while nothing is committed.

Parameters:
- ADDR_W, 11, buffer address width; depth = 2**ADDR_W bytes
- MAX_PKT, 64, max bytes per IN transaction (1..2**ADDR_W)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- usb_in_addr  in  11  client write byte address
- usb_in_data  in  8  client write data
- usb_in_wren  in  1  client write strobe, one byte per cycle
- usb_in_commit  in  1  level; client holds high until it sees commit_ack fall
- usb_in_commit_len  in  11  reply length in bytes, sampled when commit is accepted
- usb_in_commit_ack  out  1  high from accept until whole reply is sent
- usb_in_ready  out  1  buffer free; client may write and commit
- tx_tok  in  1  one-cycle pulse: IN token received for EP1
- tx_nak  out  1  one-cycle pulse answering a token with nothing to send
- tx_valid  out  1  stream byte valid
- tx_data  out  8  stream byte
- tx_last  out  1  marks last byte of this transaction; zero-length packet (ZLP) = tx_valid with tx_last and tx_zlp
- tx_zlp  out  1  qualifies the tx_valid/tx_last beat as zero-length (tx_data ignored)
- tx_ready  in  1  stream accept
- tx_done  in  1  pulse: host ACKed the last transaction
- tx_abort  in  1  pulse: no host ACK, rewind to transaction start

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0 except usb_in_ready=1; pointers 0. RAM contents undefined.
- RAM: simple dual-port, write from client, registered read (1-cycle latency). Writes are accepted in any state. Writes while ready=0 corrupt the pending reply; this is a client error and is not checked.
- IDLE: ready=1.
  - A token here gives tx_nak the following cycle.
  - commit==1 latches len (clamped to 2**ADDR_W), sets base=0, ack=1, ready=0, and moves to WAIT_TOK.
- WAIT_TOK:
  - A token starts SEND when remaining>0, or when remaining==0 and a ZLP is owed (see below).
  - Otherwise no token is expected. A stray token gets tx_nak and the state is unchanged.
- SEND:
  - chunk = min(remaining, MAX_PKT).
  - Prefetch the byte at base the cycle after entry; tx_valid rises 2 cycles after the token.
  - Byte i is presented until tx_ready. Back-to-back beats when tx_ready is held high; the read address advances on accept.
  - tx_last is high on byte chunk-1. After the last accept, go to WAIT_ACK.
  - len==0 commit: the first token sends a ZLP.
- WAIT_ACK:
  - tx_done: base += chunk, remaining -= chunk. If remaining==0 and no ZLP is owed, go to DONE; else go to WAIT_TOK.
  - tx_abort: base unchanged; go to WAIT_TOK. The next token resends the identical chunk.
  - tx_done and tx_abort in the same cycle: abort wins.
  - Tokens while in SEND or WAIT_ACK are ignored, with no NAK.
- DONE: ack=0 for one cycle, then RELEASE.
- RELEASE: wait for commit==0 (the client drops it about 2 cycles after the ack fall), then IDLE with ready=1. A commit held high here is never re-accepted.
- Arithmetic: remaining and base are 12 bits, so len 2048 is representable after the clamp. base does not wrap within a reply.
- Reset mid-transfer: tx_valid drops the same cycle; the reply is discarded.

Optional Feature:
- JOKER_EP_IN_ZLP_EN.
  - Defined: when a reply ends exactly on a MAX_PKT boundary (len>0 and len%MAX_PKT==0), one extra ZLP transaction is owed before DONE.
  - Undefined: no trailing ZLP; the len==0 commit still sends a single ZLP.

Decomposition:
- Shared package/header (alongside the J_CMD codes): state encoding constants (ST_IDLE, ST_WAIT_TOK, ST_SEND, ST_WAIT_ACK, ST_DONE, ST_RELEASE), default MAX_PKT, and buffer address width.
- One sub-module: joker_ep_in_ram, a 2**ADDR_W x 8 dual-port RAM with registered read.
- FSM, pointers and stream logic stay in the top.

Test Plan:
- Reply of 2 bytes: write 0x0A@0, 0x5C@1, commit len=2, one token -> stream 0A,5C with tx_last on 5C. After tx_done: ack falls, ready returns after commit drops.
- Reply of 150 bytes at MAX_PKT=64 -> three transactions of 64/64/22 bytes on three tokens; ack held high throughout.
- tx_abort after the 2nd chunk -> the next token replays the identical 64 bytes starting at offset 64.
- Token while IDLE -> tx_nak pulse, no tx_valid.
- len=128 with JOKER_EP_IN_ZLP_EN -> 64, 64, then a ZLP beat before ack falls. Without the macro, ack falls after the 2nd tx_done.
- tx_ready toggling 1/0 every cycle -> data sequence intact; reset asserted mid-SEND -> outputs reset next edge, ready=1.
